// File: rtl/rtc_bus_sched_pkg.sv
// Shared types and RTC register map for the RTC bus scheduler.
package rtc_bus_sched_pkg;

  // Scheduler FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Owner of the transaction currently on the engine.
  typedef enum logic [1:0] {
    REQ_UART = 2'd0,
    REQ_KEY  = 2'd1,
    REQ_POLL = 2'd2
  } req_id_e;

  // Every access starts at the seconds register; the length selects time-only
  // (sec/min/hour) or the full time+date block.
  localparam logic [7:0] RTC_ADDR_TIME = 8'h00;
  localparam logic [2:0] RTC_LEN_FULL  = 3'd7;
  localparam logic [2:0] RTC_LEN_TIME  = 3'd3;

  // Saturating 8-bit increment for the error counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/rtc_bus_sched_poll.sv
// Poll tick divider: free-running 0..PERIOD-1 counter, tick high on the wrap cycle.
module rtc_poll_tick #(
  parameter int unsigned PERIOD = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Wrap detection and next count.
  always_comb begin
    tick  = (cnt_q == LAST);
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/rtc_bus_sched.sv
// RTC bus scheduler: arbitrates UART set, key adjust and periodic poll reads
// onto a single I2C transaction engine, with timeout, retry and error count.
// Handshake: uart_wr_req / key_wr_req are levels held by the requester until
// the matching one-cycle ack; the ack fires once per request, on success or
// on drop. eng_start is a one-cycle command; eng_done (with eng_nack/eng_rdata)
// is only honoured while the scheduler is waiting for it.
module rtc_bus_sched
  import rtc_bus_sched_pkg::*;
#(
  parameter int unsigned SYSCLKHZ    = 50_000_000,
  parameter int unsigned POLL_HZ     = 10,
  parameter int unsigned TIMEOUT_CYC = 1_000_000,
  parameter int unsigned MAX_RETRY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_wr_req,
  input  logic [55:0] uart_wr_data,
  output logic        uart_wr_ack,
  input  logic        key_wr_req,
  input  logic [23:0] key_wr_time,
  output logic        key_wr_ack,
  output logic        eng_start,
  output logic        eng_rw,
  output logic [7:0]  eng_addr,
  output logic [2:0]  eng_len,
  output logic [55:0] eng_wdata,
  input  logic        eng_done,
  input  logic        eng_nack,
  input  logic [55:0] eng_rdata,
  output logic [23:0] time_read,
  output logic [31:0] date_read,
  output logic        read_done,
  output logic [7:0]  err_cnt
);

  localparam int unsigned POLL_PERIOD = SYSCLKHZ / POLL_HZ;
  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  state_e        state_q,     state_d;
  req_id_e       owner_q,     owner_d;
  logic          eng_rw_q,    eng_rw_d;
  logic [7:0]    eng_addr_q,  eng_addr_d;
  logic [2:0]    eng_len_q,   eng_len_d;
  logic [55:0]   eng_wdata_q, eng_wdata_d;
  logic [TW-1:0] tmo_q,       tmo_d;
  logic [RW-1:0] retry_q,     retry_d;
  logic          fail_q,      fail_d;
  logic          poll_pend_q, poll_pend_d;
  logic [23:0]   time_read_q, time_read_d;
  logic [31:0]   date_read_q, date_read_d;
  logic [7:0]    err_cnt_q,   err_cnt_d;

  logic tick;
  logic pend_set;
  logic pend_clr;

  rtc_poll_tick #(
    .PERIOD (POLL_PERIOD)
  ) u_poll_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Next-state, command fields and completion pulses.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    eng_rw_d    = eng_rw_q;
    eng_addr_d  = eng_addr_q;
    eng_len_d   = eng_len_q;
    eng_wdata_d = eng_wdata_q;
    tmo_d       = tmo_q;
    retry_d     = retry_q;
    fail_d      = fail_q;
    time_read_d = time_read_q;
    date_read_d = date_read_q;
    err_cnt_d   = err_cnt_q;
    pend_set    = 1'b0;
    pend_clr    = 1'b0;
    eng_start   = 1'b0;
    uart_wr_ack = 1'b0;
    key_wr_ack  = 1'b0;
    read_done   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Fixed priority: UART set, then key adjust, then pending poll.
        if (uart_wr_req) begin
          owner_d     = REQ_UART;
          eng_rw_d    = 1'b0;
          eng_addr_d  = RTC_ADDR_TIME;
          eng_len_d   = RTC_LEN_FULL;
          eng_wdata_d = uart_wr_data;
          retry_d     = '0;
          state_d     = ST_START;
        end else if (key_wr_req) begin
          owner_d     = REQ_KEY;
          eng_rw_d    = 1'b0;
          eng_addr_d  = RTC_ADDR_TIME;
          eng_len_d   = RTC_LEN_TIME;
          eng_wdata_d = {32'd0, key_wr_time};
          retry_d     = '0;
          state_d     = ST_START;
        end else if (poll_pend_q) begin
          owner_d     = REQ_POLL;
          eng_rw_d    = 1'b1;
          eng_addr_d  = RTC_ADDR_TIME;
          eng_len_d   = RTC_LEN_FULL;
          eng_wdata_d = '0;
          retry_d     = '0;
          state_d     = ST_START;
        end
      end

      ST_START: begin
        eng_start = 1'b1;
        tmo_d     = '0;
        state_d   = ST_WAIT;
      end

      ST_WAIT: begin
        // Read data is captured on the completing edge so it is already
        // visible while read_done is high in DONE.
        if (eng_done) begin
          fail_d  = eng_nack;
          state_d = ST_DONE;
          if (!eng_nack && eng_rw_q) begin
            time_read_d = eng_rdata[23:0];
            date_read_d = eng_rdata[55:24];
          end
        end else if (tmo_q == TMO_LAST) begin
          fail_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      ST_DONE: begin
        // A retry re-issues the same command fields straight from DONE;
        // everything else returns to IDLE for the next grant.
        if (!fail_q) begin
          state_d = ST_IDLE;
          if (eng_rw_q) begin
            read_done = 1'b1;
            pend_clr  = 1'b1;
          end else begin
            uart_wr_ack = (owner_q == REQ_UART);
            key_wr_ack  = (owner_q == REQ_KEY);
            pend_set    = 1'b1;
          end
        end else if (retry_q < RETRY_MAX) begin
          retry_d = retry_q + RW'(1);
          state_d = ST_START;
        end else begin
          state_d   = ST_IDLE;
          err_cnt_d = sat_inc8(err_cnt_q);
          if (eng_rw_q) begin
            pend_clr = 1'b1;
          end else begin
            uart_wr_ack = (owner_q == REQ_UART);
            key_wr_ack  = (owner_q == REQ_KEY);
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // A tick wrap in the same cycle as a clear keeps the poll pending.
    poll_pend_d = poll_pend_q;
    if (pend_clr)          poll_pend_d = 1'b0;
    if (pend_set || tick)  poll_pend_d = 1'b1;
  end

  // State and datapath registers; reset leaves a poll pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= REQ_POLL;
      eng_rw_q    <= 1'b0;
      eng_addr_q  <= '0;
      eng_len_q   <= '0;
      eng_wdata_q <= '0;
      tmo_q       <= '0;
      retry_q     <= '0;
      fail_q      <= 1'b0;
      poll_pend_q <= 1'b1;
      time_read_q <= '0;
      date_read_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      eng_rw_q    <= eng_rw_d;
      eng_addr_q  <= eng_addr_d;
      eng_len_q   <= eng_len_d;
      eng_wdata_q <= eng_wdata_d;
      tmo_q       <= tmo_d;
      retry_q     <= retry_d;
      fail_q      <= fail_d;
      poll_pend_q <= poll_pend_d;
      time_read_q <= time_read_d;
      date_read_q <= date_read_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign eng_rw    = eng_rw_q;
  assign eng_addr  = eng_addr_q;
  assign eng_len   = eng_len_q;
  assign eng_wdata = eng_wdata_q;
  assign time_read = time_read_q;
  assign date_read = date_read_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_rtc_bus_sched.sv
// Self-checking bench for rtc_bus_sched with an I2C engine model and a
// transaction-level scoreboard of expected write commands.
module tb_rtc_bus_sched;

  localparam int unsigned SYSCLKHZ    = 1000;
  localparam int unsigned POLL_HZ     = 10;
  localparam int unsigned TIMEOUT_CYC = 50;
  localparam int unsigned MAX_RETRY   = 2;
  localparam int unsigned PERIOD      = SYSCLKHZ / POLL_HZ;
  localparam logic [55:0] RTC_VAL     = 56'h23_11_05_03_12_34_56;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        uart_wr_req = 1'b0;
  logic [55:0] uart_wr_data = '0;
  logic        uart_wr_ack;
  logic        key_wr_req = 1'b0;
  logic [23:0] key_wr_time = '0;
  logic        key_wr_ack;
  logic        eng_start;
  logic        eng_rw;
  logic [7:0]  eng_addr;
  logic [2:0]  eng_len;
  logic [55:0] eng_wdata;
  logic        eng_done = 1'b0;
  logic        eng_nack = 1'b0;
  logic [55:0] eng_rdata = '0;
  logic [23:0] time_read;
  logic [31:0] date_read;
  logic        read_done;
  logic [7:0]  err_cnt;

  rtc_bus_sched #(
    .SYSCLKHZ    (SYSCLKHZ),
    .POLL_HZ     (POLL_HZ),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .MAX_RETRY   (MAX_RETRY)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .uart_wr_req  (uart_wr_req),
    .uart_wr_data (uart_wr_data),
    .uart_wr_ack  (uart_wr_ack),
    .key_wr_req   (key_wr_req),
    .key_wr_time  (key_wr_time),
    .key_wr_ack   (key_wr_ack),
    .eng_start    (eng_start),
    .eng_rw       (eng_rw),
    .eng_addr     (eng_addr),
    .eng_len      (eng_len),
    .eng_wdata    (eng_wdata),
    .eng_done     (eng_done),
    .eng_nack     (eng_nack),
    .eng_rdata    (eng_rdata),
    .time_read    (time_read),
    .date_read    (date_read),
    .read_done    (read_done),
    .err_cnt      (err_cnt)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  // Entry: {owner_is_key, len[2:0], wdata[55:0]} for each write the requesters issue.
  logic [59:0] exp_q[$];

  // ---------------- engine model / monitor ----------------
  int          lat_cnt     = -1;
  int          nack_left   = 0;
  bit          silent_wr   = 0;
  bit          rand_lat    = 0;
  bit          rand_rd     = 0;
  bit          spur_req    = 0;
  logic [55:0] rd_val      = RTC_VAL;
  logic [55:0] last_rd_val = '0;
  bit          cur_rw      = 0;
  logic [7:0]  cap_addr;
  logic [2:0]  cap_len;
  logic [55:0] cap_wdata;
  int          n_start = 0, n_rd_start = 0, n_wr_start = 0;
  int          n_uart_ack = 0, n_key_ack = 0, n_read_done = 0;
  int unsigned last_wr_start = 0, prev_wr_start = 0;
  int unsigned last_rd_start = 0, prev_rd_start = 0;
  int unsigned ack_cyc = 0;

  initial begin
    forever begin
      @(negedge clk);
      eng_done = 1'b0;
      eng_nack = 1'b0;
      if (spur_req) begin
        eng_done  = 1'b1;
        eng_rdata = 56'hAA_BB_CC_DD_EE_FF_11;
        spur_req  = 0;
      end
      if (lat_cnt > 0) begin
        lat_cnt--;
        if (lat_cnt == 0) begin
          lat_cnt  = -1;
          eng_done = 1'b1;
          check_eq("fields_stable_rw", eng_rw, cur_rw);
          check_eq("fields_stable_addr", eng_addr, cap_addr);
          check_eq("fields_stable_len", eng_len, cap_len);
          check_eq("fields_stable_wdata", eng_wdata, cap_wdata);
          if (nack_left > 0) begin
            eng_nack = 1'b1;
            nack_left--;
          end
          if (cur_rw) begin
            if (rand_rd) rd_val = {$urandom(), $urandom()};
            eng_rdata = rd_val;
            if (!eng_nack) last_rd_val = rd_val;
          end else begin
            eng_rdata = '0;
          end
        end
      end
      if (eng_start) begin
        n_start++;
        cur_rw    = eng_rw;
        cap_addr  = eng_addr;
        cap_len   = eng_len;
        cap_wdata = eng_wdata;
        check_eq("start_addr", eng_addr, 8'h00);
        if (eng_rw) begin
          n_rd_start++;
          prev_rd_start = last_rd_start;
          last_rd_start = cyc;
          check_eq("read_len", eng_len, 3'd7);
        end else begin
          n_wr_start++;
          prev_wr_start = last_wr_start;
          last_wr_start = cyc;
          if (exp_q.size() == 0) begin
            check_eq("write_expected", 0, 1);
          end else begin
            logic [59:0] e;
            e = exp_q[0];
            check_eq("write_len", eng_len, e[58:56]);
            check_eq("write_wdata", eng_wdata, e[55:0]);
          end
        end
        if (!(silent_wr && !eng_rw)) lat_cnt = rand_lat ? int'($urandom_range(1, 8)) : 5;
      end
      if (uart_wr_ack || key_wr_ack) begin
        ack_cyc = cyc;
        if (uart_wr_ack) n_uart_ack++;
        if (key_wr_ack)  n_key_ack++;
        check_eq("ack_single_owner", uart_wr_ack & key_wr_ack, 0);
        if (exp_q.size() == 0) begin
          check_eq("ack_expected", 0, 1);
        end else begin
          logic [59:0] e;
          e = exp_q.pop_front();
          check_eq("ack_owner_is_key", key_wr_ack, e[59]);
        end
      end
      if (read_done) begin
        n_read_done++;
        check_eq("time_read", time_read, last_rd_val[23:0]);
        check_eq("date_read", date_read, last_rd_val[55:24]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_uart(input logic [55:0] d, input int bound);
    bit seen;
    seen = 0;
    uart_wr_data = d;
    uart_wr_req  = 1'b1;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      if (uart_wr_ack) seen = 1;
    end
    uart_wr_req = 1'b0;
    check_eq("uart_ack_seen", seen, 1);
  endtask

  task automatic drive_key(input logic [23:0] t, input int bound);
    bit seen;
    seen = 0;
    key_wr_time = t;
    key_wr_req  = 1'b1;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      if (key_wr_ack) seen = 1;
    end
    key_wr_req = 1'b0;
    check_eq("key_ack_seen", seen, 1);
  endtask

  task automatic wait_read_done(input string tag, input int bound);
    int base;
    bit seen;
    base = n_read_done;
    seen = 0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      if (n_read_done != base) seen = 1;
    end
    check_eq(tag, seen, 1);
  endtask

  task automatic wait_rd_starts(input string tag, input int target, input int bound);
    bit seen;
    seen = (n_rd_start >= target);
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      if (n_rd_start >= target) seen = 1;
    end
    check_eq(tag, seen, 1);
  endtask

  // Idle point: just after a poll read completes, far from the next tick.
  task automatic wait_quiet();
    wait_read_done("quiet_read_done", 3 * PERIOD);
    repeat (2) @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int s0, u0, k0, r0, w0, d0;
    logic [55:0] ud;
    logic [23:0] kd;
    logic [23:0] t_keep;

    // Reset values.
    repeat (3) @(negedge clk);
    check_eq("rst_eng_start", eng_start, 0);
    check_eq("rst_eng_rw", eng_rw, 0);
    check_eq("rst_eng_addr", eng_addr, 0);
    check_eq("rst_eng_len", eng_len, 0);
    check_eq("rst_eng_wdata", eng_wdata, 0);
    check_eq("rst_time_read", time_read, 0);
    check_eq("rst_date_read", date_read, 0);
    check_eq("rst_read_done", read_done, 0);
    check_eq("rst_err_cnt", err_cnt, 0);
    check_eq("rst_acks", {uart_wr_ack, key_wr_ack}, 0);
    rst = 1'b0;

    // Poll read right after reset, then one read per poll period.
    wait_rd_starts("read_after_reset", 1, 3);
    wait_read_done("first_read_done", 20);
    check_eq("first_time", time_read, 24'h123456);
    check_eq("first_date", date_read, 32'h23110503);
    wait_rd_starts("periodic_reads", 3, 3 * PERIOD);
    check_eq("poll_interval", last_rd_start - prev_rd_start, PERIOD);

    // Simultaneous UART and key requests: UART first, key second, then a read.
    wait_quiet();
    ud = 56'h24_01_15_02_09_30_00;
    kd = 24'h10_45_20;
    exp_q.push_back({1'b0, 3'd7, ud});
    exp_q.push_back({1'b1, 3'd3, 32'd0, kd});
    u0 = n_uart_ack; k0 = n_key_ack; r0 = n_rd_start;
    fork
      drive_uart(ud, 100);
      drive_key(kd, 100);
    join
    wait_read_done("read_after_writes", 40);
    check_eq("dual_uart_acks", n_uart_ack - u0, 1);
    check_eq("dual_key_acks", n_key_ack - k0, 1);
    check_eq("dual_one_read", n_rd_start - r0, 1);

    // Two NACKs then success: three attempts, one ack, no error.
    wait_quiet();
    nack_left = 2;
    ud = 56'h25_12_31_06_23_59_59;
    exp_q.push_back({1'b0, 3'd7, ud});
    w0 = n_wr_start; u0 = n_uart_ack;
    drive_uart(ud, 100);
    check_eq("nack_attempts", n_wr_start - w0, 3);
    check_eq("nack_acks", n_uart_ack - u0, 1);
    check_eq("nack_err_cnt", err_cnt, 0);

    // Engine silent on writes: three timed-out attempts, then dropped.
    wait_quiet();
    silent_wr = 1;
    kd = 24'h07_08_09;
    exp_q.push_back({1'b1, 3'd3, 32'd0, kd});
    w0 = n_wr_start; k0 = n_key_ack;
    drive_key(kd, 400);
    check_eq("tmo_attempts", n_wr_start - w0, 3);
    check_eq("tmo_retry_spacing", last_wr_start - prev_wr_start, TIMEOUT_CYC + 2);
    check_eq("tmo_ack_latency", ack_cyc - last_wr_start, TIMEOUT_CYC + 1);
    check_eq("tmo_acks", n_key_ack - k0, 1);
    @(negedge clk);
    check_eq("tmo_err_cnt", err_cnt, 1);
    silent_wr = 0;

    // Reset in the middle of a write: no ack, reset values, read after release.
    wait_quiet();
    silent_wr = 1;
    kd = 24'h11_22_33;
    exp_q.push_back({1'b1, 3'd3, 32'd0, kd});
    k0 = n_key_ack; w0 = n_wr_start;
    key_wr_time = kd;
    key_wr_req  = 1'b1;
    for (int i = 0; i < 10 && n_wr_start == w0; i++) @(negedge clk);
    check_eq("rst_mid_write_started", n_wr_start - w0, 1);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    key_wr_req = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    check_eq("rst_mid_err_cnt", err_cnt, 0);
    check_eq("rst_mid_time", time_read, 0);
    check_eq("rst_mid_date", date_read, 0);
    check_eq("rst_mid_len", eng_len, 0);
    check_eq("rst_mid_wdata", eng_wdata, 0);
    check_eq("rst_mid_start", eng_start, 0);
    silent_wr = 0;
    r0 = n_rd_start;
    rst = 1'b0;
    wait_rd_starts("rst_mid_read_after", r0 + 1, 3);
    wait_read_done("rst_mid_read_done", 20);
    check_eq("rst_mid_no_ack", n_key_ack - k0, 0);

    // Spurious eng_done while idle.
    wait_quiet();
    s0 = n_start; d0 = n_read_done; u0 = n_uart_ack; k0 = n_key_ack;
    t_keep = time_read;
    spur_req = 1;
    repeat (6) @(negedge clk);
    check_eq("spur_no_start", n_start - s0, 0);
    check_eq("spur_no_read_done", n_read_done - d0, 0);
    check_eq("spur_no_ack", (n_uart_ack - u0) + (n_key_ack - k0), 0);
    check_eq("spur_time_kept", time_read, t_keep);

    // Randomized traffic with random engine latency and read data.
    rand_lat = 1;
    rand_rd  = 1;
    u0 = n_uart_ack; k0 = n_key_ack;
    for (int it = 0; it < 24; it++) begin
      int kind;
      repeat ($urandom_range(0, 30)) @(negedge clk);
      kind = $urandom_range(0, 2);
      ud = {$urandom(), $urandom()};
      kd = $urandom();
      if (kind == 0) begin
        exp_q.push_back({1'b0, 3'd7, ud});
        drive_uart(ud, 100);
      end else if (kind == 1) begin
        exp_q.push_back({1'b1, 3'd3, 32'd0, kd});
        drive_key(kd, 100);
      end else begin
        exp_q.push_back({1'b0, 3'd7, ud});
        exp_q.push_back({1'b1, 3'd3, 32'd0, kd});
        fork
          drive_uart(ud, 100);
          drive_key(kd, 100);
        join
      end
    end
    wait_read_done("rand_final_read", 40);
    check_eq("rand_scoreboard_empty", exp_q.size(), 0);
    check_eq("rand_err_cnt", err_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
